// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ID/EX side, the execute ALU and the EX/MEM side.
// The master drives operations and consumes results; the slave is the ALU.
interface alu_exec_unit_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       operation;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic             busy;

    modport master (
        output in_valid, operation, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, busy
    );

    modport slave (
        input  in_valid, operation, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/add/sub/compare, fixed-latency iterative
// shift-add multiply, registered result behind a valid/ready output slot.
module alu_exec_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    alu_exec_unit_if.slave  bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic {IDLE, MUL} state_t;

    state_t             state, state_next;
    logic               out_valid, out_valid_next;
    logic [WIDTH-1:0]   result, result_next;
    logic               illegal, illegal_next;
    logic [WIDTH-1:0]   mcand, mcand_next;
    logic [WIDTH-1:0]   mplier, mplier_next;
    logic [WIDTH-1:0]   acc, acc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    logic               accept;
    logic               out_fire;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ill;
    logic [WIDTH-1:0]   acc_sum;

    assign bus.in_ready  = (state == IDLE) && !flush && (!out_valid || bus.out_ready);
    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.zero      = (result == '0);
    assign bus.illegal   = illegal;
    assign bus.busy      = (state == MUL);

    assign accept   = bus.in_valid && bus.in_ready;
    assign out_fire = out_valid && bus.out_ready;
    assign acc_sum  = mplier[0] ? (acc + mcand) : acc;

    // Single-cycle datapath; unknown codes produce a zero result flagged illegal.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (bus.operation)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_ADD:  alu_res = bus.a + bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            out_valid <= out_valid_next;
            result    <= result_next;
            illegal   <= illegal_next;
            mcand     <= mcand_next;
            mplier    <= mplier_next;
            acc       <= acc_next;
            cnt       <= cnt_next;
        end
    end

    // Flush overrides everything; the held result stays put but is no longer valid.
    always_comb begin
        state_next     = state;
        out_valid_next = out_valid;
        result_next    = result;
        illegal_next   = illegal;
        mcand_next     = mcand;
        mplier_next    = mplier;
        acc_next       = acc;
        cnt_next       = cnt;

        if (flush) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
            cnt_next       = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (out_fire) begin
                        out_valid_next = 1'b0;
                    end
                    if (accept) begin
                        if (bus.operation == OP_MUL) begin
                            mcand_next  = bus.a;
                            mplier_next = bus.b;
                            acc_next    = '0;
                            cnt_next    = CNT_W'(WIDTH);
                            state_next  = MUL;
                        end else begin
                            result_next    = alu_res;
                            illegal_next   = alu_ill;
                            out_valid_next = 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_next    = acc_sum;
                    mcand_next  = mcand << 1;
                    mplier_next = mplier >> 1;
                    cnt_next    = cnt - CNT_W'(1);
                    // Latency is fixed at WIDTH iterations even if the multiplier runs out early.
                    if (cnt == CNT_W'(1)) begin
                        result_next    = acc_sum;
                        illegal_next   = 1'b0;
                        out_valid_next = 1'b1;
                        state_next     = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver queues model results on accept,
// the monitor pops and compares on every output transfer.
module tb_alu_exec_unit;
    localparam int WIDTH = 64;

    typedef struct {
        logic [WIDTH-1:0] result;
        logic             illegal;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   compared;
    int   mismatched;
    exp_t scoreboard[$];

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] observed,
                               input logic [WIDTH-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed=0x%h expected=0x%h", tag, observed, expected);
        end
    endtask

    // Independent reference model of the operation codes.
    function automatic exp_t modelAlu(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
        exp_t e;
        e.result  = '0;
        e.illegal = 1'b0;
        case (op)
            4'b0010: e.result = x + y;
            4'b0110: e.result = x - y;
            4'b0000: e.result = x & y;
            4'b0001: e.result = x | y;
            4'b0111: e.result = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'b1000: e.result = x * y;
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                 input logic [WIDTH-1:0] y, output int stalls);
        bus.operation = op;
        bus.a         = x;
        bus.b         = y;
        bus.in_valid  = 1'b1;
        stalls        = 0;
        @(negedge clk);
        while (!bus.in_ready && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        scoreboard.push_back(modelAlu(op, x, y));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitMul(output int cycles, output int bad);
        cycles = 0;
        bad    = 0;
        while (!bus.out_valid && cycles < 200) begin
            if (!bus.busy || bus.in_ready) bad++;
            @(posedge clk);
            cycles++;
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (scoreboard.size() == 0) begin
                checkOutput("unexpected_out", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = scoreboard.pop_front();
                checkOutput("sb_result", bus.result, e.result);
                checkOutput("sb_zero", {63'd0, bus.zero}, {63'd0, (e.result == '0)});
                checkOutput("sb_illegal", {63'd0, bus.illegal}, {63'd0, e.illegal});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stalls;
        int cycles;
        int bad;
        int seen;
        bit randDone;
        logic [3:0] opTable [7];
        opTable = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1000, 4'b1011};

        compared      = 0;
        mismatched    = 0;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.operation = 4'b0000;
        bus.a         = '0;
        bus.b         = '0;

        #1;
        checkOutput("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rst_result", bus.result, 64'd0);
        checkOutput("rst_zero", {63'd0, bus.zero}, 64'd1);
        checkOutput("rst_illegal", {63'd0, bus.illegal}, 64'd0);
        checkOutput("rst_busy", {63'd0, bus.busy}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] ADD 5+7");
        applyStimulus(4'b0010, 64'd5, 64'd7, stalls);
        checkOutput("add_valid", {63'd0, bus.out_valid}, 64'd1);
        checkOutput("add_result", bus.result, 64'd12);
        checkOutput("add_zero", {63'd0, bus.zero}, 64'd0);

        $display("[TB] back-to-back SUB/SLT/SLT");
        applyStimulus(4'b0110, 64'd9, 64'd9, stalls);
        checkOutput("b2b_stall0", 64'(stalls), 64'd0);
        checkOutput("sub_zero", {63'd0, bus.zero}, 64'd1);
        applyStimulus(4'b0111, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, stalls);
        checkOutput("b2b_stall1", 64'(stalls), 64'd0);
        applyStimulus(4'b0111, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, stalls);
        checkOutput("b2b_stall2", 64'(stalls), 64'd0);
        checkOutput("slt_result", bus.result, 64'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] MUL 3 * -1");
        applyStimulus(4'b1000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, stalls);
        waitMul(cycles, bad);
        checkOutput("mul_latency", 64'(cycles), 64'd64);
        checkOutput("mul_busy_stall", 64'(bad), 64'd0);
        checkOutput("mul_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(4'b1000, 64'h1_0000_0000, 64'h1_0000_0000, stalls);
        waitMul(cycles, bad);
        checkOutput("mul2_latency", 64'(cycles), 64'd64);
        checkOutput("mul2_zero", {63'd0, bus.zero}, 64'd1);
        @(posedge clk);
        #1;

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        applyStimulus(4'b0010, 64'd1, 64'd1, stalls);
        fork
            applyStimulus(4'b0000, 64'hF0, 64'h3C, stalls);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("bp_hold", bus.result, 64'd2);
                    checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        checkOutput("bp_and_result", bus.result, 64'h30);
        @(posedge clk);
        #1;

        $display("[TB] flush mid-MUL");
        applyStimulus(4'b1000, 64'd7, 64'd9, stalls);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", {63'd0, bus.in_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(scoreboard.pop_back());
        #1;
        checkOutput("flush_out_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("flush_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("flush_ready", {63'd0, bus.in_ready}, 64'd1);
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checkOutput("flush_no_out", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] reset mid-MUL");
        applyStimulus(4'b1000, 64'd5, 64'd6, stalls);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        void'(scoreboard.pop_back());
        checkOutput("rstmul_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("rstmul_valid", {63'd0, bus.out_valid}, 64'd0);
        checkOutput("rstmul_result", bus.result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (70) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checkOutput("rstmul_no_out", 64'(seen), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] illegal op then ADD");
        applyStimulus(4'b0101, 64'd4, 64'd4, stalls);
        checkOutput("ill_flag", {63'd0, bus.illegal}, 64'd1);
        checkOutput("ill_zero", {63'd0, bus.zero}, 64'd1);
        applyStimulus(4'b0010, 64'd2, 64'd3, stalls);
        checkOutput("ill_cleared", {63'd0, bus.illegal}, 64'd0);

        $display("[TB] random ops with random backpressure");
        randDone = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    applyStimulus(opTable[$urandom_range(0, 6)],
                                  {$urandom, $urandom}, {$urandom, $urandom}, stalls);
                end
                randDone = 1'b1;
            end
            begin
                while (!randDone) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join

        cycles = 0;
        while (scoreboard.size() != 0 && cycles < 200) begin
            @(posedge clk);
            cycles++;
        end
        @(posedge clk);
        checkOutput("drain", 64'(scoreboard.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
